unary_add_sequencer: RTL and testbench
======================================

// Module: unary_add_sequencer
// PURPOSE
//  Front-end controller for a serial unary adder: accepts binary operand pairs, converts them to
//  thermometer streams and drives the adder's en / read_or_write. It then counts the adder's
//  unary dout burst back into binary and returns it with a done pulse.
//  Sits between a binary requester and one Unary_add_* instance; owns that instance's
//  enable, mode and clear.
// PARAMETERS
//  W          4   operand width (a_val, b_val)
//  STREAM_LEN 15  READ-phase cycles (input stream length); must be >= 2^W-1
//  OUT_LEN    32  WRITE-phase dout sampling cycles
//  DOUT_LAT   1   cycles from add_rw=1 to first valid add_dout
//  RES_W      6   result width; must hold OUT_LEN
// PORTS
//  clk       in   1      clock, all logic on rising edge
//  rst_n     in   1      synchronous active-low reset
//  start     in   1      request strobe, accepted when start & ready
//  a_val     in   W      operand A (binary)
//  b_val     in   W      operand B (binary)
//  ready     out  1      request can be accepted this cycle
//  done      out  1      one-cycle pulse, result valid
//  result    out  RES_W  count of dout ones in the last WRITE window; held until next done
//  carry     out  1      sticky OR of add_C over the last operation; updated with done
//  add_A     out  1      unary stream A to adder
//  add_B     out  1      unary stream B to adder
//  add_en    out  1      adder enable
//  add_rw    out  1      adder read_or_write (0=read/accumulate, 1=write/emit)
//  add_rst_n out  1      adder reset = rst_n & ~clr (clr high only in LOAD)
//  add_dout  in   1      adder serial unary output
//  add_C     in   1      adder carry/overflow flag
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, idx=0, acc=0, result=0, carry=0, done=0,
//   add_en=add_rw=add_A=add_B=0; add_rst_n follows rst_n; queue slot (if built) emptied.
//   Reset mid-operation aborts it with no done pulse.
//  FSM IDLE -> LOAD -> READ -> WRITE -> DONE -> IDLE.
//  IDLE : ready=1; start -> latch a_val,b_val into op regs, go LOAD.
//  LOAD : 1 cycle; clr=1 (add_rst_n=0), add_en=0; clear acc, c_flag, idx; go READ.
//  READ : STREAM_LEN cycles; add_en=1, add_rw=0;
//         add_A=(idx<opA), add_B=(idx<opB) (thermometer, ones first); idx++;
//         at idx==STREAM_LEN-1: idx=0, go WRITE.
//  WRITE: OUT_LEN+DOUT_LAT cycles; add_en=1, add_rw=1, add_A=add_B=0;
//         when idx>=DOUT_LAT: acc+=add_dout, saturating at 2^RES_W-1;
//         c_flag|=add_C every cycle; at last cycle go DONE.
//  DONE : 1 cycle; done=1, result<=acc, carry<=c_flag, add_en=0; go IDLE.
//  Latency: start accepted in cycle 0 -> done in cycle 2+STREAM_LEN+OUT_LEN+DOUT_LAT.
//  Ops latched at accept; a_val/b_val changes later have no effect.
//  add_A/add_B/add_en/add_rw are registered outputs (no combinational path from inputs).
//  start with ready=0: ignored, no state change.
//  idx width = clog2(max(STREAM_LEN,OUT_LEN+DOUT_LAT)+1); no wrap inside a phase.
// CONFIGURATION
//  UNARY_SEQ_QUEUE_EN defined: one-entry request slot. ready = IDLE | slot empty.
//   start & ready in a non-IDLE state writes the slot. In DONE with slot full, go LOAD
//   directly: ops <= slot, slot emptied, done still pulses for the finished op.
//   Back-to-back gap = 0 idle cycles. start in the DONE cycle with empty slot fills the slot.
//  Undefined: no slot; ready=1 only in IDLE; one idle cycle between operations.
// TESTING (W=4, STREAM_LEN=15, OUT_LEN=32, DOUT_LAT=1; behavioural adder: dout emits ones(A)+ones(B))
//  1 a=3,b=5 start -> add_A high 3 READ cycles, add_B 5; done at cycle 50; result=8, carry=0
//  2 a=0,b=0 -> add_A=add_B=0 throughout READ; result=0; a=15,b=15 -> result=30
//  3 add_C forced 1 for one WRITE cycle -> carry=1 at done; next op with add_C=0 -> carry=0
//  4 rst_n=0 for one cycle mid-READ -> next cycle IDLE, add_en=0, no done; new start runs normally
//  5 start while busy -> ignored (no QUEUE_EN); with UNARY_SEQ_QUEUE_EN: 2nd op (a=2,b=7)
//    enters LOAD in the cycle after first done, result=9, ready=0 while slot full
//  6 RES_W=4, model emitting 20 ones -> result saturates at 15

Source files
------------

// File: rtl/unary_add_sequencer.sv
// ---------------------------------------------------------------------------
// unary_add_sequencer
//   Front-end controller for a serial unary adder. It accepts a binary operand
//   pair and plays it into the adder as two thermometer streams (ones first)
//   during READ. It then switches the adder to WRITE and counts the ones of
//   the adder's unary dout burst back into binary. The count is returned
//   with a one-cycle done pulse.
//
//   Optional feature (macro UNARY_SEQ_QUEUE_EN):
//     Adds a one-entry request slot, so a second request can be accepted
//     while an operation is running. That request starts in the cycle after
//     the current operation's done pulse, with no idle cycle in between.
//     With the macro undefined, requests are accepted only in IDLE.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   request strobe, accepted when start & ready
//   a_val      in   operand A (binary, W bits)
//   b_val      in   operand B (binary, W bits)
//   ready      out  request can be accepted this cycle
//   done       out  one-cycle pulse, result/carry valid
//   result     out  ones counted in the last WRITE window (saturating)
//   carry      out  sticky OR of add_C over the last operation
//   add_A      out  unary stream A to adder
//   add_B      out  unary stream B to adder
//   add_en     out  adder enable
//   add_rw     out  adder mode (0 = accumulate, 1 = emit)
//   add_rst_n  out  adder reset, low during reset and during LOAD
//   add_dout   in   adder serial unary output
//   add_C      in   adder carry/overflow flag
// ---------------------------------------------------------------------------
module unary_add_sequencer #(
    parameter int W          = 4,
    parameter int STREAM_LEN = 15,
    parameter int OUT_LEN    = 32,
    parameter int DOUT_LAT   = 1,
    parameter int RES_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a_val,
    input  logic [W-1:0]     b_val,
    output logic             ready,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             carry,
    output logic             add_A,
    output logic             add_B,
    output logic             add_en,
    output logic             add_rw,
    output logic             add_rst_n,
    input  logic             add_dout,
    input  logic             add_C
);

    localparam int WRITE_LEN = OUT_LEN + DOUT_LAT;
    localparam int IDX_MAX   = (STREAM_LEN > WRITE_LEN) ? STREAM_LEN : WRITE_LEN;
    localparam int IDX_W     = $clog2(IDX_MAX + 1);
    localparam int CMP_W     = (IDX_W > W) ? IDX_W : W;
    localparam logic [RES_W-1:0] ACC_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [W-1:0]       op_a_reg;
    logic [W-1:0]       op_b_reg;
    logic [RES_W-1:0]   acc_reg;
    logic               c_flag_reg;
    logic               done_reg;
    logic [RES_W-1:0]   result_reg;
    logic               carry_reg;
    logic               add_a_reg;
    logic               add_b_reg;
    logic               add_en_reg;
    logic               add_rw_reg;
    logic [RES_W-1:0]   acc_next;
    logic [IDX_W-1:0]   idx_inc;

`ifdef UNARY_SEQ_QUEUE_EN
    logic [W-1:0]       slot_a_reg;
    logic [W-1:0]       slot_b_reg;
    logic               slot_full_reg;
`endif

    // Thermometer bit for stream position i: ones first, op ones in total.
    function automatic logic therm(input logic [IDX_W-1:0] i, input logic [W-1:0] op);
        return CMP_W'(i) < CMP_W'(op);
    endfunction

    assign idx_inc = idx_reg + IDX_W'(1);

    // The first DOUT_LAT WRITE cycles carry no valid dout; the count saturates.
    always_comb begin
        acc_next = acc_reg;
        if ((idx_reg >= IDX_W'(DOUT_LAT)) && add_dout && (acc_reg != ACC_MAX)) begin
            acc_next = acc_reg + RES_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            acc_reg    <= '0;
            c_flag_reg <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            add_a_reg  <= 1'b0;
            add_b_reg  <= 1'b0;
            add_en_reg <= 1'b0;
            add_rw_reg <= 1'b0;
`ifdef UNARY_SEQ_QUEUE_EN
            slot_a_reg    <= '0;
            slot_b_reg    <= '0;
            slot_full_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef UNARY_SEQ_QUEUE_EN
            // A request arriving while busy parks in the slot.
            if (start && !slot_full_reg && (state_reg != S_IDLE)) begin
                slot_a_reg    <= a_val;
                slot_b_reg    <= b_val;
                slot_full_reg <= 1'b1;
            end
`endif
            case (state_reg)
                S_IDLE: begin
`ifdef UNARY_SEQ_QUEUE_EN
                    // A request parked during the DONE cycle is served first;
                    // a simultaneous new start refills the slot.
                    if (slot_full_reg) begin
                        op_a_reg  <= slot_a_reg;
                        op_b_reg  <= slot_b_reg;
                        state_reg <= S_LOAD;
                        if (start) begin
                            slot_a_reg <= a_val;
                            slot_b_reg <= b_val;
                        end else begin
                            slot_full_reg <= 1'b0;
                        end
                    end else if (start) begin
                        op_a_reg  <= a_val;
                        op_b_reg  <= b_val;
                        state_reg <= S_LOAD;
                    end
`else
                    if (start) begin
                        op_a_reg  <= a_val;
                        op_b_reg  <= b_val;
                        state_reg <= S_LOAD;
                    end
`endif
                end
                S_LOAD: begin
                    acc_reg    <= '0;
                    c_flag_reg <= 1'b0;
                    idx_reg    <= '0;
                    // Outputs are registered, so the first READ bit is prepared here.
                    add_en_reg <= 1'b1;
                    add_rw_reg <= 1'b0;
                    add_a_reg  <= therm('0, op_a_reg);
                    add_b_reg  <= therm('0, op_b_reg);
                    state_reg  <= S_READ;
                end
                S_READ: begin
                    if (idx_reg == IDX_W'(STREAM_LEN - 1)) begin
                        idx_reg    <= '0;
                        add_a_reg  <= 1'b0;
                        add_b_reg  <= 1'b0;
                        add_rw_reg <= 1'b1;
                        state_reg  <= S_WRITE;
                    end else begin
                        idx_reg   <= idx_inc;
                        add_a_reg <= therm(idx_inc, op_a_reg);
                        add_b_reg <= therm(idx_inc, op_b_reg);
                    end
                end
                S_WRITE: begin
                    acc_reg    <= acc_next;
                    c_flag_reg <= c_flag_reg | add_C;
                    if (idx_reg == IDX_W'(WRITE_LEN - 1)) begin
                        // Publish on the way into DONE so result and done line up.
                        idx_reg    <= '0;
                        result_reg <= acc_next;
                        carry_reg  <= c_flag_reg | add_C;
                        done_reg   <= 1'b1;
                        add_en_reg <= 1'b0;
                        add_rw_reg <= 1'b0;
                        state_reg  <= S_DONE;
                    end else begin
                        idx_reg <= idx_inc;
                    end
                end
                S_DONE: begin
`ifdef UNARY_SEQ_QUEUE_EN
                    if (slot_full_reg) begin
                        op_a_reg      <= slot_a_reg;
                        op_b_reg      <= slot_b_reg;
                        slot_full_reg <= 1'b0;
                        state_reg     <= S_LOAD;
                    end else begin
                        state_reg <= S_IDLE;
                    end
`else
                    state_reg <= S_IDLE;
`endif
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef UNARY_SEQ_QUEUE_EN
    assign ready = (state_reg == S_IDLE) || !slot_full_reg;
`else
    assign ready = (state_reg == S_IDLE);
`endif

    assign done      = done_reg;
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign add_A     = add_a_reg;
    assign add_B     = add_b_reg;
    assign add_en    = add_en_reg;
    assign add_rw    = add_rw_reg;
    assign add_rst_n = rst_n & (state_reg != S_LOAD);

endmodule

// File: tb/tb_unary_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_unary_add_sequencer
//   Directed bench for unary_add_sequencer. A behavioural unary adder counts
//   A/B ones while accumulating. In emit mode it returns that many dout ones,
//   one cycle after the mode switch. A second instance with RES_W=4 checks
//   that the result saturates.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unary_add_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a_val, b_val;
    logic       ready, done, carry;
    logic [5:0] result;
    logic       add_A, add_B, add_en, add_rw, add_rst_n, add_dout, add_c;

    logic       s_start;
    logic [3:0] s_a, s_b;
    logic       s_ready, s_done, s_carry;
    logic [3:0] s_result;
    logic       s_add_A, s_add_B, s_add_en, s_add_rw, s_add_rst_n, s_add_dout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unary_add_sequencer #(.W(4), .STREAM_LEN(15), .OUT_LEN(32), .DOUT_LAT(1), .RES_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_val(a_val), .b_val(b_val),
        .ready(ready), .done(done), .result(result), .carry(carry),
        .add_A(add_A), .add_B(add_B), .add_en(add_en), .add_rw(add_rw),
        .add_rst_n(add_rst_n), .add_dout(add_dout), .add_C(add_c)
    );

    unary_add_sequencer #(.W(4), .STREAM_LEN(15), .OUT_LEN(32), .DOUT_LAT(1), .RES_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .a_val(s_a), .b_val(s_b),
        .ready(s_ready), .done(s_done), .result(s_result), .carry(s_carry),
        .add_A(s_add_A), .add_B(s_add_B), .add_en(s_add_en), .add_rw(s_add_rw),
        .add_rst_n(s_add_rst_n), .add_dout(s_add_dout), .add_C(1'b0)
    );

    // Behavioural unary adders (one per instance).
    logic [6:0] cnt, s_cnt;
    always @(posedge clk) begin
        if (!add_rst_n) begin
            cnt <= '0; add_dout <= 1'b0;
        end else if (add_en && !add_rw) begin
            cnt <= cnt + 7'(add_A) + 7'(add_B); add_dout <= 1'b0;
        end else if (add_en && add_rw && cnt != 0) begin
            cnt <= cnt - 7'd1; add_dout <= 1'b1;
        end else begin
            add_dout <= 1'b0;
        end
    end
    always @(posedge clk) begin
        if (!s_add_rst_n) begin
            s_cnt <= '0; s_add_dout <= 1'b0;
        end else if (s_add_en && !s_add_rw) begin
            s_cnt <= s_cnt + 7'(s_add_A) + 7'(s_add_B); s_add_dout <= 1'b0;
        end else if (s_add_en && s_add_rw && s_cnt != 0) begin
            s_cnt <= s_cnt - 7'd1; s_add_dout <= 1'b1;
        end else begin
            s_add_dout <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bounded wait for done, called at a negedge; n = negedges waited.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full operation. Cycle k=0 is the accept cycle; samples at negedges.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int c_at,
                          output logic [5:0] res, output logic car, output int lat,
                          output int na, output int nb, output int nen, output int nrw);
        int k;
        int wcyc;
        na = 0; nb = 0; nen = 0; nrw = 0; lat = -1; res = '0; car = 1'b0;
        @(negedge clk);
        start = 1'b1; a_val = a; b_val = b;
        @(negedge clk);
        start = 1'b0; a_val = ~a; b_val = ~b;   // must not affect the running op
        k = 1; wcyc = 0;
        while (k < 200) begin
            add_c = 1'b0;
            if (k == 1) check("load_clr", {31'd0, add_rst_n}, 32'd0);
            if (add_en) nen++;
            if (add_en && !add_rw) begin na += int'(add_A); nb += int'(add_B); end
            if (add_en && add_rw) begin
                if (wcyc == c_at) add_c = 1'b1;
                wcyc++;
                nrw++;
            end
            if (done) begin
                lat = k; res = result; car = carry;
                break;
            end
            @(negedge clk);
            k++;
        end
        add_c = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         c_at;    // WRITE cycle to pulse add_C, -1 for none
        logic [5:0] res;
        logic       car;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [5:0] r;
        logic       c;
        int lat, na, nb, nen, nrw, n, extra;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  c_at: -1, res: 6'd8,  car: 1'b0};
        vecs[1] = '{a: 4'd0,  b: 4'd0,  c_at: -1, res: 6'd0,  car: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd15, c_at: -1, res: 6'd30, car: 1'b0};
        vecs[3] = '{a: 4'd7,  b: 4'd1,  c_at: 5,  res: 6'd8,  car: 1'b1};
        vecs[4] = '{a: 4'd4,  b: 4'd4,  c_at: -1, res: 6'd8,  car: 1'b0};
        vecs[5] = '{a: 4'd15, b: 4'd0,  c_at: -1, res: 6'd15, car: 1'b0};
        vecs[6] = '{a: 4'd1,  b: 4'd14, c_at: -1, res: 6'd15, car: 1'b0};

        rst_n = 1'b0; start = 1'b0; a_val = '0; b_val = '0; add_c = 1'b0;
        s_start = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(negedge clk);
        check("rst_add_rst_n", {31'd0, add_rst_n}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_result", {26'd0, result}, 32'd0);
        check("rst_carry",  {31'd0, carry},  32'd0);
        check("rst_add_en", {31'd0, add_en}, 32'd0);
        check("rst_add_rw", {31'd0, add_rw}, 32'd0);
        check("rst_ab",     {30'd0, add_A, add_B}, 32'd0);
        check("rst_ready",  {31'd0, ready},  32'd1);

        // Table-driven operations.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c_at, r, c, lat, na, nb, nen, nrw);
            $display("op a=%0d b=%0d -> result=%0d carry=%0d latency=%0d", vecs[i].a, vecs[i].b, r, c, lat);
            check("latency", lat, 32'd50);
            check("result",  {26'd0, r}, {26'd0, vecs[i].res});
            check("carry",   {31'd0, c}, {31'd0, vecs[i].car});
            check("a_ones",  na, {28'd0, vecs[i].a});
            check("b_ones",  nb, {28'd0, vecs[i].b});
            check("en_cycles", nen, 32'd48);
            check("rw_cycles", nrw, 32'd33);
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd0);
            check("result_hold", {26'd0, result}, {26'd0, vecs[i].res});
        end

        // Reset for one cycle in the middle of READ aborts the operation.
        @(negedge clk);
        start = 1'b1; a_val = 4'd6; b_val = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_en",    {31'd0, add_en}, 32'd0);
        check("abort_ready", {31'd0, ready},  32'd1);
        extra = 0;
        repeat (70) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("abort_no_done", extra, 32'd0);
        $display("abort mid-READ: spurious done count=%0d", extra);
        run_op(4'd2, 4'd3, -1, r, c, lat, na, nb, nen, nrw);
        $display("op a=2 b=3 after abort -> result=%0d latency=%0d", r, lat);
        check("post_abort_result", {26'd0, r}, 32'd5);
        check("post_abort_lat", lat, 32'd50);

        // Second start while busy.
        @(negedge clk);
        start = 1'b1; a_val = 4'd3; b_val = 4'd5;
        @(negedge clk);
        start = 1'b0;                                  // k=1
        repeat (8) @(negedge clk);                     // k=9
        check("busy_ready_before", {31'd0, ready},
`ifdef UNARY_SEQ_QUEUE_EN
              32'd1);
`else
              32'd0);
`endif
        start = 1'b1; a_val = 4'd2; b_val = 4'd7;
        @(negedge clk);                                // k=10
        start = 1'b0;
`ifdef UNARY_SEQ_QUEUE_EN
        check("slot_full_ready", {31'd0, ready}, 32'd0);
`endif
        wait_done(100, n);
        $display("busy op1 -> result=%0d latency=%0d", result, 10 + n);
        check("busy_lat1", n, 32'd40);
        check("busy_res1", {26'd0, result}, 32'd8);
`ifdef UNARY_SEQ_QUEUE_EN
        @(negedge clk);
        check("queued_load", {31'd0, add_rst_n}, 32'd0);
        wait_done(100, n);
        $display("queued op2 -> result=%0d gap=%0d", result, 1 + n);
        check("queued_lat", n, 32'd49);
        check("queued_res", {26'd0, result}, 32'd9);
        @(negedge clk);
`else
        @(negedge clk);
        extra = 0;
        repeat (80) begin
            if (done) extra++;
            @(negedge clk);
        end
        $display("busy start ignored: extra done count=%0d", extra);
        check("busy_ignored", extra, 32'd0);
`endif

        // Saturation with RES_W=4: 20 ones clip to 15.
        @(negedge clk);
        s_start = 1'b1; s_a = 4'd10; s_b = 4'd10;
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (!s_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("sat op a=10 b=10 -> result=%0d latency=%0d", s_result, n + 1);
        check("sat_lat", n + 1, 32'd50);
        check("sat_result", {28'd0, s_result}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
